// File: rtl/pull_emulator_bank.sv
// Pull-resistor emulation for IO boards without hardware pulls: every period each enabled pad is
// driven to its pull level, released, left to settle, then sampled through a 2-flop sync and filter.

module pull_emulator_lane #(
    parameter int   FILTER   = 2,
    parameter logic INIT_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_in,
    input  logic load,
    input  logic eval,
    output logic out,
    output logic changed
);
    localparam int            FW    = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [FW-1:0] FLAST = FW'(FILTER - 1);

    logic [1:0]    sync;
    logic          smp;
    logic [FW-1:0] fcnt;
    logic          hit;

    // hit: this evaluation is the FILTER-th consecutive sample disagreeing with out
    assign hit     = (smp != out) && (fcnt == FLAST);
    assign changed = eval && hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            smp  <= INIT_BIT;
            fcnt <= '0;
            out  <= INIT_BIT;
        end else begin
            sync <= {sync[0], pad_in};
            if (load) smp <= sync[1];
            if (eval) begin
                if ((smp == out) || hit) fcnt <= '0;
                else                     fcnt <= fcnt + 1'b1;
                if (hit) out <= smp;
            end
        end
    end
endmodule

module pull_emulator_bank #(
    parameter int               WIDTH         = 8,
    parameter int               PERIOD        = 16,
    parameter int               DRIVE_CYCLES  = 2,
    parameter int               SETTLE_CYCLES = 3,
    parameter int               FILTER        = 2,
    parameter logic [WIDTH-1:0] INIT          = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire [WIDTH-1:0]  pad,
    input  logic [WIDTH-1:0] pull_en,
    input  logic [WIDTH-1:0] pull_up,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] changed,
    output logic             sample_strobe
);
    localparam int SAMPLE_AT = DRIVE_CYCLES + SETTLE_CYCLES + 2;
    localparam int CW        = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    if (DRIVE_CYCLES < 1 || SETTLE_CYCLES < 1 || FILTER < 1 || SAMPLE_AT > PERIOD - 1) begin : g_bad_cfg
        $error("pull_emulator_bank: invalid DRIVE/SETTLE/FILTER/PERIOD combination");
    end

    logic [CW-1:0]    cnt, cnt_nxt;
    logic             wrap;
    logic [WIDTH-1:0] cfg_en, cfg_up, en_nxt, up_nxt, oe;
    logic             load;

    assign cnt_nxt = (cnt == CW'(PERIOD - 1)) ? '0 : cnt + 1'b1;
    assign wrap    = (cnt_nxt == '0);
    // Config is captured on the edge entering cnt==0 so the new period drives with it from cycle 0
    assign en_nxt  = wrap ? pull_en : cfg_en;
    assign up_nxt  = wrap ? pull_up : cfg_up;
    assign load    = (cnt == CW'(SAMPLE_AT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            cfg_en        <= '0;
            cfg_up        <= '0;
            oe            <= '0;
            sample_strobe <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            cfg_en        <= en_nxt;
            cfg_up        <= up_nxt;
            oe            <= (cnt_nxt < CW'(DRIVE_CYCLES)) ? en_nxt : '0;
            sample_strobe <= (cnt_nxt == CW'(SAMPLE_AT + 1));
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign pad[i] = oe[i] ? cfg_up[i] : 1'bz;

        pull_emulator_lane #(
            .FILTER   (FILTER),
            .INIT_BIT (INIT[i])
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .pad_in  (pad[i]),
            .load    (load),
            .eval    (sample_strobe),
            .out     (out[i]),
            .changed (changed[i])
        );
    end
endmodule

// File: tb/tb_pull_emulator_bank.sv
// Bench for pull_emulator_bank: directed scenarios plus randomized pulls/switches, checked each
// cycle against a period-level reference model of drive windows, sampling and filtering.
module tb_pull_emulator_bank;
    localparam int           W    = 8;
    localparam int           P    = 16;
    localparam int           D    = 2;
    localparam int           S    = 3;
    localparam int           F    = 2;
    localparam logic [W-1:0] INIT = 8'hF0;
    localparam int           SA   = D + S + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] pull_en, pull_up, out, changed;
    logic         sample_strobe;
    wire  [W-1:0] pad;
    logic [W-1:0] tb_oe, tb_val;

    for (genvar i = 0; i < W; i++) begin : g_env
        assign pad[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    always #5 clk = ~clk;

    pull_emulator_bank #(
        .WIDTH(W), .PERIOD(P), .DRIVE_CYCLES(D), .SETTLE_CYCLES(S), .FILTER(F), .INIT(INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pad(pad), .pull_en(pull_en), .pull_up(pull_up),
        .out(out), .changed(changed), .sample_strobe(sample_strobe)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: phase within the period, latched config, filtered level, mismatch streaks
    int           ph;
    logic [W-1:0] m_en, m_up, m_out, sv, pcur, dd;
    logic [W-1:0] press, press_val, flt;
    int           mm [W];
    logic         exp_strobe;
    logic [W-1:0] exp_chg;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at t=%0t ph=%0d", tag, obs, exp, $time, ph);
        end
    endtask

    // Environment: a pressed switch wins; otherwise a keeper holds the pull level, or a float value
    task automatic drive_env();
        logic [W-1:0] env;
        for (int i = 0; i < W; i++) begin
            dd[i]   = m_en[i] && (ph < D);
            env[i]  = press[i] ? press_val[i] : (m_en[i] ? m_up[i] : flt[i]);
            pcur[i] = dd[i] ? m_up[i] : env[i];
        end
        tb_oe  = ~dd;
        tb_val = env;
    endtask

    task automatic step();
        drive_env();
        @(posedge clk);
        #1;
        if (ph == SA - 2) sv = pcur;
        if (ph == SA + 1) begin
            for (int i = 0; i < W; i++) begin
                if (sv[i] == m_out[i]) mm[i] = 0;
                else begin
                    mm[i]++;
                    if (mm[i] == F) begin
                        m_out[i] = sv[i];
                        mm[i]    = 0;
                    end
                end
            end
        end
        if (ph == P - 1) begin
            m_en = pull_en;
            m_up = pull_up;
        end
        ph = (ph + 1) % P;
        exp_strobe = (ph == SA + 1);
        for (int i = 0; i < W; i++)
            exp_chg[i] = exp_strobe && (sv[i] != m_out[i]) && (mm[i] + 1 == F);
        drive_env();
        #1;
        chk("out", out, m_out);
        chk("changed", changed, exp_chg);
        chk("strobe", W'(sample_strobe), W'(exp_strobe));
        if (dd != '0) chk("pad_drive", pad & dd, m_up & dd);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_to(input int p);
        int k = 0;
        while (ph != p && k < 2 * P) begin
            step();
            k++;
        end
        checks++;
        if (ph != p) begin
            failures++;
            $error("FAIL run_to observed=%0d expected=%0d", ph, p);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        ph         = 0;
        m_en       = '0;
        m_up       = '0;
        m_out      = INIT;
        sv         = INIT;
        exp_strobe = 1'b0;
        exp_chg    = '0;
        foreach (mm[i]) mm[i] = 0;
        drive_env();
        #1;
        chk("rst_out", out, INIT);
        chk("rst_changed", changed, '0);
        chk("rst_strobe", W'(sample_strobe), '0);
        chk("rst_pad", pad, tb_val);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_hold_out", out, INIT);
        rst_n = 1'b1;
    endtask

    initial begin
        pull_en = '0; pull_up = '0; press = '0; press_val = '0; flt = 8'h3C;
        ph = 0; m_en = '0; m_up = '0; m_out = INIT; sv = INIT; dd = '0;
        #1;
        do_reset();

        // Pull-down on all channels, switches open
        pull_en = '1; pull_up = '0;
        run(4 * P);

        // Pull-up; ch2 button to ground for three periods
        pull_up = '1;
        run(3 * P);
        run_to(0);
        press[2] = 1'b1; press_val[2] = 1'b0;
        run(3 * P);
        press = '0;
        run(3 * P);

        // Pull-down; ch1 glitch high for exactly one period
        pull_up = '0;
        run(3 * P);
        run_to(0);
        press[1] = 1'b1; press_val[1] = 1'b1;
        run(P);
        press = '0;
        run(3 * P);
        chk("glitch_hold", out, '0);

        // Config change mid-period on ch3
        pull_en = 8'hF7; pull_up = 8'h08;
        run(2 * P);
        run_to(5);
        pull_en[3] = 1'b1;
        run(2 * P);

        // Randomized pulls, switches and floating inputs
        for (int k = 0; k < 40; k++) begin
            press     = $urandom & $urandom;
            press_val = $urandom;
            flt       = $urandom;
            for (int c = 0; c < P; c++) begin
                if ($urandom_range(0, 15) == 0) pull_en = $urandom;
                if ($urandom_range(0, 15) == 0) pull_up = $urandom;
                if ($urandom_range(0, 31) == 0) press[$urandom_range(0, W - 1)] ^= 1'b1;
                step();
            end
        end

        // Reset during the drive window: pads must be released at once
        pull_en = '1; pull_up = 8'h5A; press = '0;
        run(2 * P);
        run_to(1);
        press = '1; press_val = 8'hA5;
        do_reset();
        press = '0; flt = $urandom;
        pull_en = $urandom; pull_up = $urandom;
        run(6 * P);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pull_emulator_bank.md
# pull_emulator_bank

Multi-channel, run-time configurable pull-resistor emulator for Alchitry Cu designs whose IO boards lack hardware pulls. Each period, every enabled channel briefly drives its pad to its pull level, releases it, waits to settle, then samples. The samples are synchronised and filtered over consecutive periods, giving clean logic levels to downstream logic. It sits directly behind the top-level inout pins, in front of debouncers and keypad scanners.

## Interface
- WIDTH, 8: number of pad channels.
- PERIOD, 16: cycles per drive/sample period; counter runs 0..PERIOD-1.
- DRIVE_CYCLES, 2: cycles per period the pad is actively driven to the pull level (>=1).
- SETTLE_CYCLES, 3: released cycles before the sampled pad value is taken (>=1).
- FILTER, 2: consecutive identical samples required to change an output (>=1).
- INIT, {WIDTH{1'b0}}: reset value of out.
- Constraint: DRIVE_CYCLES+SETTLE_CYCLES+2 <= PERIOD-1 (elaboration error otherwise).

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pad  inout  WIDTH  physical pins.
- pull_en  in  WIDTH  1 = emulate a pull on this channel; 0 = plain input, never driven.
- pull_up  in  WIDTH  1 = pull high, 0 = pull low (ignored where pull_en=0).
- out  out  WIDTH  filtered pad level.
- changed  out  WIDTH  one-cycle pulse per channel whose out toggled this cycle.
- sample_strobe  out  1  one-cycle pulse each period when out is re-evaluated.

## Operation
- Phase counter cnt: increments each clk, wraps PERIOD-1 -> 0.
- Config latch: at cnt==0, pull_en/pull_up are registered into cfg_en/cfg_up. Mid-period changes take effect only at the next cnt==0. Reset clears cfg_en (all pads released).
- Pad drive: pad[i] = cfg_up[i] when cnt < DRIVE_CYCLES and cfg_en[i]; otherwise high-Z. Drive uses a registered output enable, so pads never glitch between channels.
- Synchroniser: 2-flop sync on every pad bit, free-running.
- Sample point: SAMPLE_AT = DRIVE_CYCLES+SETTLE_CYCLES+2. At the edge ending cycle cnt==SAMPLE_AT, smp <= synchronised value. This is the pad level after SETTLE_CYCLES released cycles.
- Filter, per channel, evaluated in the cycle after the sample point (cnt==SAMPLE_AT+1):
  - if smp[i]==out[i]: fcnt[i] <= 0.
  - else if fcnt[i]==FILTER-1: out[i] <= smp[i], fcnt[i] <= 0, changed[i] pulses.
  - else: fcnt[i] <= fcnt[i]+1.
- fcnt width is clog2(FILTER), minimum 1 bit. FILTER=1 updates on every differing sample.
- sample_strobe is high exactly at the edge where out/changed update, every period, even if nothing changed.
- Undriven channel (pull_en=0), floating pad: whatever sync sees passes through the filter. No guarantee; the filter only suppresses single-period noise.

## Timing
- Reset (rst_n low, async): cnt=0, pads high-Z immediately, cfg_en=0, cfg_up=0, sync=0, smp=INIT, fcnt=0, out=INIT, changed=0, sample_strobe=0.
- First drive after reset release: the period starting at the first cnt==0 after rst_n rises, using the pull_en/pull_up values present then.
- Latency, pad change to out: worst case FILTER*PERIOD + SAMPLE_AT + 1 cycles; best case (FILTER-1)*PERIOD + 1 from the sample edge.
- Reset asserted mid-period: drive stops that instant. Partial filter counts are discarded, not resumed.
- A sample matching out between mismatches restarts the count; mismatches need not be the same value as each other only if equal to !out (1-bit, so always equal).

## Test plan
- Reset: WIDTH=4, INIT=4'b0101, hold rst_n low during drive phase -> pad all Z within the same cycle, out=0101, changed=0, sample_strobe=0.
- Pull-down, open switch: pull_en=F, pull_up=0, pad externally Z (weak-keeper model retains last driven level), defaults PERIOD=16/DRIVE=2/SETTLE=3/FILTER=2 -> pad driven 0 at cnt 0..1, Z at 2..15; out stays 0; sample_strobe pulses at cnt==8 every period.
- Pull-up, button to ground: pull_up=F, pull_en=F, INIT=F; external 0 on pad[2] from period 3 -> out[2] falls and changed[2] pulses at cnt==8 of period 4 (second consecutive sample). Other bits stay 1.
- Glitch rejection: external 1 on pad[1] (pull-down) for exactly one sample period -> out[1] never changes, changed[1]=0, fcnt[1] returns to 0 next period.
- Config change mid-period: set pull_en[3]=1 at cnt==5 -> pad[3] not driven until next cnt==0; driven at cnt 0..1 of the following period only.
- FILTER=1, PERIOD=8, DRIVE=1, SETTLE=1: toggle an external driver each period -> out follows every sample. changed pulses every period, 1 cycle after cnt==4.
